lfsr_pulse_scheduler: RTL and testbench

//  Pseudo-random pulse source for the random pulse generator top level. A 16-bit LFSR

---
 rtl/lfsr_pulse_scheduler.sv | 119 +++++++++++
 tb/tb_lfsr_pulse_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_pulse_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : lfsr_pulse_scheduler
// Brief   : 16-bit LFSR driven random pulse source with fixed width and gap.
//           Optional macro SEED_LOAD_EN adds a runtime seed-load port pair.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr_pulse_scheduler #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          PULSE_W = 4,
  parameter int          MIN_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  density,
  output logic        pulse,
  output logic        busy,
  output logic [15:0] lfsr_q
`ifdef SEED_LOAD_EN
  ,
  input  logic        seed_load,
  input  logic [15:0] seed_val
`endif
);

  localparam logic [15:0] c_seed       = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [7:0]  c_pulse_last = 8'(PULSE_W - 1);
  localparam logic [7:0]  c_gap_last   = (MIN_GAP == 0) ? 8'd0 : 8'(MIN_GAP - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_high = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] w_lfsr_nxt;
  logic [15:0] w_lfsr_step;
  logic        w_hit;
  logic        w_load;
  logic [15:0] w_load_val;

`ifdef SEED_LOAD_EN
  assign w_load     = seed_load;
  assign w_load_val = (seed_val == 16'h0000) ? 16'hACE1 : seed_val;
`else
  assign w_load     = 1'b0;
  assign w_load_val = c_seed;
`endif

  assign w_lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign w_hit       = (lfsr_q[7:0] < density);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = lfsr_q;
    if (w_load) begin
      w_lfsr_nxt  = w_load_val;
      w_state_nxt = c_st_idle;
      w_cnt_nxt   = 8'd0;
    end else if (!ena) begin
      w_state_nxt = c_st_idle;
      w_cnt_nxt   = 8'd0;
    end else begin
      w_lfsr_nxt = w_lfsr_step;
      case (r_state)
        c_st_idle: begin
          if (w_hit) begin
            w_state_nxt = c_st_high;
            w_cnt_nxt   = c_pulse_last;
          end
        end
        c_st_high: begin
          // Terminal count is checked before decrementing, so the counter never wraps.
          if (r_cnt == 8'd0) begin
            w_state_nxt = (MIN_GAP == 0) ? c_st_idle : c_st_gap;
            w_cnt_nxt   = c_gap_last;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        c_st_gap: begin
          if (r_cnt == 8'd0) begin
            w_state_nxt = c_st_idle;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Outputs decode the next state so pulse rises on the same edge that enters HIGH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_cnt   <= 8'd0;
      lfsr_q  <= c_seed;
      pulse   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      lfsr_q  <= w_lfsr_nxt;
      pulse   <= (w_state_nxt == c_st_high);
      busy    <= (w_state_nxt != c_st_idle);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_pulse_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_lfsr_pulse_scheduler
// Brief   : Directed self-checking bench for lfsr_pulse_scheduler (default build).
// Revision: 1.0 - initial release
// ============================================================================
module tb_lfsr_pulse_scheduler;

  localparam int c_pw = 4;
  localparam int c_mg = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  density = 8'd0;
  logic        pulse;
  logic        busy;
  logic [15:0] lfsr_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected LFSR value and remaining busy cycles (high + gap).
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_left = 0;
  int          m_hits = 0;
  int          e_lfsr = 0;
  int          e_pulse = 0;
  int          e_busy = 0;

  lfsr_pulse_scheduler #(.SEED(16'hACE1), .PULSE_W(c_pw), .MIN_GAP(c_mg)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .density (density),
    .pulse   (pulse),
    .busy    (busy),
    .lfsr_q  (lfsr_q)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic fb;
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    return {q[14:0], fb};
  endfunction

  // Advance model and DUT by one clock, then tally per-cycle disagreements.
  task automatic cycle();
    if (!ena) begin
      m_left = 0;
    end else begin
      if (m_left > 0) m_left--;
      else if (m_lfsr[7:0] < density) begin
        m_left = c_pw + c_mg;
        m_hits++;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    @(posedge clk);
    #1;
    if (lfsr_q !== m_lfsr) e_lfsr++;
    if (pulse !== (m_left > c_mg)) e_pulse++;
    if (busy !== (m_left > 0)) e_busy++;
  endtask

  initial begin
    logic [15:0] saved;
    int pulses_seen, zeros_seen, hi_run, lo_run, bad_hi, bad_lo, rises;
    bit found, seen_any;
    logic prev;

    // 1. reset held with clock running
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_pulse", {31'd0, pulse}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_lfsr", {16'd0, lfsr_q}, 32'h0000ACE1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ena0_hold", {16'd0, lfsr_q}, 32'h0000ACE1);

    // 2. density 0: no pulses, full period back to seed
    ena = 1'b1;
    density = 8'd0;
    @(posedge clk);
    #1;
    check_eq("lfsr_step1", {16'd0, lfsr_q}, 32'h000059C3);
    @(posedge clk);
    #1;
    check_eq("lfsr_step2", {16'd0, lfsr_q}, 32'h0000B387);
    pulses_seen = 0;
    zeros_seen = 0;
    for (int i = 2; i < 65535; i++) begin
      @(posedge clk);
      #1;
      if (pulse) pulses_seen++;
      if (lfsr_q == 16'h0000) zeros_seen++;
    end
    check_eq("d0_no_pulse", pulses_seen, 0);
    check_eq("lfsr_no_zero", zeros_seen, 0);
    check_eq("lfsr_period", {16'd0, lfsr_q}, 32'h0000ACE1);
    m_lfsr = 16'hACE1;
    m_left = 0;

    // 3. density 255: pulse shape and hit count against the model
    density = 8'd255;
    hi_run = 0; lo_run = 0; bad_hi = 0; bad_lo = 0; rises = 0;
    seen_any = 1'b0;
    m_hits = 0;
    prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      if (pulse) begin
        if (!prev) begin
          rises++;
          if (seen_any && lo_run < 3) bad_lo++;
          seen_any = 1'b1;
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (prev && hi_run != c_pw) bad_hi++;
        hi_run = 0;
        lo_run++;
      end
      prev = pulse;
    end
    check_eq("d255_lfsr_track", e_lfsr, 0);
    check_eq("d255_pulse_track", e_pulse, 0);
    check_eq("d255_busy_track", e_busy, 0);
    check_eq("d255_high_width", bad_hi, 0);
    check_eq("d255_min_gap", bad_lo, 0);
    check_eq("d255_hit_count", rises, m_hits);
    check_eq("d255_some_hits", {31'd0, (rises > 100)}, 32'd1);

    // 4. drop ena two cycles into a pulse
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (pulse && m_left == c_pw + c_mg) found = 1'b1;
    end
    check_eq("ena_pulse_found", {31'd0, found}, 32'd1);
    cycle();
    check_eq("ena_second_high", {31'd0, pulse}, 32'd1);
    saved = m_lfsr;
    ena = 1'b0;
    cycle();
    check_eq("ena_drop_pulse", {31'd0, pulse}, 32'd0);
    check_eq("ena_drop_busy", {31'd0, busy}, 32'd0);
    check_eq("ena_drop_lfsr", {16'd0, lfsr_q}, {16'd0, saved});
    repeat (3) cycle();
    check_eq("ena_frozen_lfsr", {16'd0, lfsr_q}, {16'd0, saved});
    ena = 1'b1;
    cycle();
    check_eq("ena_resume_lfsr", {16'd0, lfsr_q}, {16'd0, lfsr_step(saved)});
    check_eq("ena_resume_pulse", {31'd0, pulse}, {31'd0, (saved[7:0] != 8'hFF)});

    // 5. asynchronous reset mid-pulse
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (pulse) found = 1'b1;
    end
    check_eq("arst_pulse_found", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pulse_now", {31'd0, pulse}, 32'd0);
    check_eq("arst_busy_now", {31'd0, busy}, 32'd0);
    check_eq("arst_lfsr_now", {16'd0, lfsr_q}, 32'h0000ACE1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    m_left = 0;
    e_lfsr = 0; e_pulse = 0; e_busy = 0;
    repeat (50) cycle();
    check_eq("post_rst_lfsr_track", e_lfsr, 0);
    check_eq("post_rst_pulse_track", e_pulse, 0);
    check_eq("post_rst_busy_track", e_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
